// File: rtl/puneh_mem_arbiter.sv
// Single-port data memory arbiter for the Puneh CPU and a DMA/IO requester.
// Every access is a fixed WAIT_CYC+1 cycle window over latched request registers.
// One IDLE cycle always separates accesses; arbitration happens only in that cycle.
module puneh_mem_arbiter #(
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned DMA_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_done,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCpuAcc = 2'd1,
    StDmaAcc = 2'd2
  } state_e;

  localparam logic [2:0] CntLast = 3'(WAIT_CYC);
  localparam logic [3:0] RunMax  = 4'(DMA_MAX);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  dma_run_q, dma_run_d;
  logic        last_dma_q, last_dma_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;

  logic cpu_req;
  logic acc_last;
  logic cpu_fin;
  logic dma_fin;
  logic grant_cpu;
  logic grant_dma;
  logic acc;

  assign cpu_req  = cpu_read | cpu_write;
  assign acc_last = (cnt_q == CntLast);
  assign cpu_fin  = (state_q == StCpuAcc) & acc_last;
  assign dma_fin  = (state_q == StDmaAcc) & acc_last;

  // Round-robin grant in IDLE; CPU forced once DMA has used up its burst allowance
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state_q == StIdle) begin
      if (cpu_req && dma_req) begin
        if (last_dma_q || (dma_run_q == RunMax)) begin
          grant_cpu = 1'b1;
        end else begin
          grant_dma = 1'b1;
        end
      end else begin
        grant_cpu = cpu_req;
        grant_dma = dma_req;
      end
    end
  end

  // FSM next state and access-cycle counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (grant_cpu) begin
          state_d = StCpuAcc;
        end else if (grant_dma) begin
          state_d = StDmaAcc;
        end
      end
      StCpuAcc, StDmaAcc: begin
        if (acc_last) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Request latching on grant, fairness bookkeeping on completion
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    if (grant_cpu) begin
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      we_d    = cpu_write;  // read+write together counts as a write
    end else if (grant_dma) begin
      addr_d  = dma_addr;
      wdata_d = dma_wdata;
      we_d    = dma_we;
    end

    last_dma_d = last_dma_q;
    if (cpu_fin) begin
      last_dma_d = 1'b0;
    end else if (dma_fin) begin
      last_dma_d = 1'b1;
    end

    dma_run_d = dma_run_q;
    if (!cpu_req || cpu_fin) begin
      dma_run_d = '0;
    end else if (dma_fin && (dma_run_q < RunMax)) begin
      dma_run_d = dma_run_q + 4'd1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dma_run_q  <= '0;
      last_dma_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dma_run_q  <= dma_run_d;
      last_dma_q <= last_dma_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
    end
  end

  // Outputs: strobes and bus held for the whole access window, data steered to owner
  always_comb begin
    acc       = (state_q != StIdle);
    mem_read  = acc & ~we_q;
    mem_write = acc & we_q;
    mem_addr  = acc ? addr_q : 16'h0000;
    mem_wdata = acc ? wdata_q : 16'h0000;
    cpu_stall = cpu_req & ~cpu_fin;
    cpu_rdata = (state_q == StCpuAcc) ? mem_rdata : 16'h0000;
    dma_done  = dma_fin;
    dma_rdata = dma_fin ? mem_rdata : 16'h0000;
  end

endmodule
